// File: rtl/intdiv_seq_77x43_pkg.sv
// Shared types and default sizes for the 77/43 sequential restoring divider.
// The state enum is common to the FSM and anything that inspects it.
package intdiv_pkg;

  localparam int INTDIV_LOGA = 77;
  localparam int INTDIV_LOGB = 43;
  localparam int INTDIV_LAT  = INTDIV_LOGA + 1;
  localparam int INTDIV_CNTW = $clog2(INTDIV_LOGA + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/intdiv_seq_77x43_if.sv
// Operand/result handshake bundle for the divider; DZ exists only when
// INTDIV_DIV0_EN is defined.
interface intdiv_seq_77x43_if
  import intdiv_pkg::*;
#(
  parameter int LOGA = INTDIV_LOGA,
  parameter int LOGB = INTDIV_LOGB
);
  logic            in_valid;
  logic            in_ready;
  logic [LOGA-1:0] A;
  logic [LOGB-1:0] B;
  logic            out_valid;
  logic            out_ready;
  logic [LOGA-1:0] Q;
  logic [LOGB-1:0] R;
`ifdef INTDIV_DIV0_EN
  logic            DZ;
`endif

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Q, R
`ifdef INTDIV_DIV0_EN
    , input DZ
`endif
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Q, R
`ifdef INTDIV_DIV0_EN
    , output DZ
`endif
  );

endinterface

// File: rtl/intdiv_seq_77x43_step.sv
// One restoring division step. The (LOGB+1)-bit working value exists only here
// for the compare; the stored remainder is always below B so LOGB bits suffice.
module intdiv_step
  import intdiv_pkg::*;
#(
  parameter int LOGB = INTDIV_LOGB
) (
  input  logic [LOGB-1:0] rem,
  input  logic            a_msb,
  input  logic [LOGB-1:0] B,
  output logic [LOGB-1:0] rem_next,
  output logic            q_bit
);

  logic [LOGB:0] rem_sh;
  logic [LOGB:0] b_ext;

  assign rem_sh   = {rem, a_msb};
  assign b_ext    = {1'b0, B};
  assign q_bit    = (rem_sh >= b_ext);
  assign rem_next = q_bit ? LOGB'(rem_sh - b_ext) : rem_sh[LOGB-1:0];

endmodule

// File: rtl/intdiv_seq_77x43.sv
// Sequential radix-2 restoring divider, 77-bit dividend / 43-bit divisor.
// Define INTDIV_DIV0_EN to expose the DZ divide-by-zero flag.
//
// state | meaning
// IDLE  | ready for operands, in_ready=1
// RUN   | one restoring step per clock, LOGA steps
// DONE  | result held on Q/R until out_valid & out_ready
module intdiv_seq_77x43
  import intdiv_pkg::*;
(
  input logic                clk,
  input logic                rst,
  intdiv_seq_77x43_if.slave  bus
);

  localparam int LOGA = INTDIV_LOGA;
  localparam int LOGB = INTDIV_LOGB;
  localparam int CNTW = INTDIV_CNTW;

  state_t          state;
  state_t          state_nxt;
  logic [LOGA-1:0] a_sh;
  logic [LOGB-1:0] b_reg;
  logic [LOGB-1:0] a_low;
  logic [LOGB-1:0] rem;
  logic [LOGB-1:0] rem_nxt;
  logic            q_bit;
  logic            b_zero;
  logic [CNTW-1:0] cnt;
  logic [LOGA-1:0] q_out;
  logic [LOGB-1:0] r_out;
  logic            accept;
  logic            last_step;
  logic            out_fire;

  assign accept    = bus.in_valid & bus.in_ready;
  assign out_fire  = bus.out_valid & bus.out_ready;
  assign last_step = (state == RUN) && (cnt == CNTW'(1));

  intdiv_step #(.LOGB(LOGB)) u_step (
    .rem      (rem),
    .a_msb    (a_sh[LOGA-1]),
    .B        (b_reg),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_fire)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    if (!rst) begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
    end
  end

  // a_sh doubles as the quotient register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_reg  <= '0;
      a_low  <= '0;
      rem    <= '0;
      b_zero <= 1'b0;
      cnt    <= '0;
      q_out  <= '0;
      r_out  <= '0;
    end else if (accept) begin
      a_sh   <= bus.A;
      b_reg  <= bus.B;
      a_low  <= bus.A[LOGB-1:0];
      b_zero <= (bus.B == '0);
      rem    <= '0;
      cnt    <= CNTW'(LOGA);
    end else if (state == RUN) begin
      a_sh <= {a_sh[LOGA-2:0], q_bit};
      rem  <= rem_nxt;
      cnt  <= cnt - CNTW'(1);
      if (last_step) begin
        q_out <= b_zero ? {LOGA{1'b1}} : {a_sh[LOGA-2:0], q_bit};
        r_out <= b_zero ? a_low : rem_nxt;
      end
    end
  end

  assign bus.Q = q_out;
  assign bus.R = r_out;

`ifdef INTDIV_DIV0_EN
  logic dz_out;

  always_ff @(posedge clk) begin
    if (rst)            dz_out <= 1'b0;
    else if (last_step) dz_out <= b_zero;
  end

  assign bus.DZ = dz_out;
`endif

endmodule

// File: tb/tb_intdiv_seq_77x43.sv
// Directed bench for intdiv_seq_77x43; DZ checks compile in with INTDIV_DIV0_EN.
module tb_intdiv_seq_77x43;
  import intdiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [76:0] ones77;
  logic [42:0] ones43;
  logic [76:0] mx34;
  logic [76:0] mx43;
  logic [76:0] a_rt;

  intdiv_seq_77x43_if bus ();

  intdiv_seq_77x43 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one operation and waits for out_valid; leaves the bench at the
  // negedge where out_valid was first seen, with out_ready still low.
  task automatic do_op(input string tag, input logic [76:0] a, input logic [42:0] b,
                       input logic [76:0] eq, input logic [42:0] er, input logic edz);
    int j;
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, bus.in_ready, 1'b1);
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    @(negedge clk);
    chk({tag, ".in_ready_busy"}, bus.in_ready, 1'b0);
    j = 0;
    while (!bus.out_valid && j < 200) begin
      @(posedge clk);
      j++;
      @(negedge clk);
    end
    // j+1 is the edge count from accept to the first edge sampling out_valid=1
    chk({tag, ".latency"}, j + 1, INTDIV_LAT);
    chk({tag, ".q"}, bus.Q, eq);
    chk({tag, ".r"}, bus.R, er);
`ifdef INTDIV_DIV0_EN
    chk({tag, ".dz"}, bus.DZ, edz);
`endif
  endtask

  task automatic finish_op(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".in_ready_after"}, bus.in_ready, 1'b1);
    chk({tag, ".out_valid_after"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b0;
    ones77 = {77{1'b1}};
    ones43 = {43{1'b1}};
    mx34   = 77'h3ffffffff;
    mx43   = 77'h7ffffffffff;
    a_rt   = mx34 * mx43;

    repeat (3) @(negedge clk);
    chk("rst.in_ready", bus.in_ready, 1'b0);
    chk("rst.out_valid", bus.out_valid, 1'b0);
    chk("rst.q", bus.Q, 77'd0);
    chk("rst.r", bus.R, 43'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.in_ready_release", bus.in_ready, 1'b1);

    do_op("max", ones77, ones43, 77'h400000000, 43'h3ffffffff, 1'b0);
    finish_op("max");

    do_op("roundtrip", a_rt, ones43, 77'h3ffffffff, 43'd0, 1'b0);
    finish_op("roundtrip");

    do_op("d100_7", 77'd100, 43'd7, 77'd14, 43'd2, 1'b0);
    finish_op("d100_7");

    do_op("d5_9", 77'd5, 43'd9, 77'd0, 43'd5, 1'b0);
    finish_op("d5_9");

    do_op("div0", 77'h123, 43'd0, ones77, 43'h123, 1'b1);
    finish_op("div0");

    do_op("hold", 77'd1000, 43'd33, 77'd30, 43'd10, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold.q", bus.Q, 77'd30);
      chk("hold.r", bus.R, 43'd10);
      chk("hold.in_ready", bus.in_ready, 1'b0);
      chk("hold.out_valid", bus.out_valid, 1'b1);
    end
    finish_op("hold");
    do_op("after_hold", 77'd12345, 43'd100, 77'd123, 43'd45, 1'b0);
    finish_op("after_hold");

    // Abort an operation at its 30th step with a synchronous reset.
    @(negedge clk);
    bus.A        = ones77;
    bus.B        = 43'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("abort.in_ready_in_rst", bus.in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("abort.out_valid", bus.out_valid, 1'b0);
    chk("abort.q", bus.Q, 77'd0);
    chk("abort.r", bus.R, 43'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort.in_ready_release", bus.in_ready, 1'b1);
    chk("abort.no_stale_valid", bus.out_valid, 1'b0);
    do_op("post_abort", 77'd100, 43'd7, 77'd14, 43'd2, 1'b0);
    finish_op("post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/intdiv_seq_77x43.md
# intdiv_seq_77x43

Sequential radix-2 restoring integer divider. It is the inverse of the 34x43 non-standard multiplier: it takes a 77-bit dividend (the multiplier's full product width) and a 43-bit divisor, and returns a 77-bit quotient and a 43-bit remainder. It sits behind multiplier outputs in reduction and self-check paths. It uses valid/ready handshakes on both sides and accepts one operation at a time.

## Interface
- LOGA, 77, dividend and quotient width
- LOGB, 43, divisor and remainder width
- LAT (localparam), LOGA+1, cycles from accept to first out_valid
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  A/B valid
- in_ready  out  1  divider can accept
- A  in  LOGA  dividend
- B  in  LOGB  divisor
- out_valid  out  1  Q/R valid
- out_ready  in  1  consumer accepts Q/R
- Q  out  LOGA  quotient floor(A/B)
- R  out  LOGB  remainder A mod B
- DZ  out  1  divide-by-zero flag (only with INTDIV_DIV0_EN)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch A, B. Clear the working remainder (LOGB+1 bits) and step counter. Go to RUN.
- RUN: one restoring step per cycle, MSB of dividend first.
  - rem' = {rem[LOGB-1:0], a_msb}.
  - If rem' >= {1'b0,B}: q bit = 1, rem = rem' - B.
  - Otherwise: q bit = 0, rem = rem'.
  - Shift the dividend register left and shift the q bit into the quotient register.
  - After LOGA steps, go to DONE.
- DONE: out_valid=1. Q and R are held stable until out_valid&out_ready, then go to IDLE. in_ready rises the cycle after.
- in_ready=0 in RUN and DONE. in_valid is ignored there; there is no queueing.
- B==0: the datapath still runs LOGA cycles, but the outputs are forced to Q={LOGA{1'b1}} and R=A[LOGB-1:0]. The B==0 check is latched at accept.
- Remainder never exceeds LOGB bits at output. The working MSB exists only for the compare.
- rst (synchronous), in any state including mid-RUN, forces the following. The in-flight operation is discarded.
  - state=IDLE
  - in_ready=1 on the cycle after reset deasserts
  - out_valid=0, Q=0, R=0, DZ=0

## Timing
- Accept at edge t. RUN occupies edges t+1..t+LOGA. out_valid=1 from t+LAT (t+78) onward.
- Back-to-back throughput: one result every LAT+1 cycles when out_ready is held at 1.
- While rst=1: in_ready=0 and out_valid=0.
- With out_valid=1 and out_ready=0, Q/R/DZ must not change.

## Configuration
- INTDIV_DIV0_EN defined:
  - Adds port DZ, which is valid with out_valid and equals 1 iff the latched B==0.
  - Q and R values on B==0 are unchanged.
- INTDIV_DIV0_EN undefined:
  - No DZ port.
  - B==0 behaviour is otherwise identical.

## Structure
- Package intdiv_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - default LOGA/LOGB constants
  - counter width $clog2(LOGA+1)
- Sub-module intdiv_step: combinational single restoring step. Inputs rem, a_msb, B. Outputs rem_next, q_bit. The top instantiates it once.

## Test plan
- A=2^77-1, B=2^43-1 -> Q=0x400000000, R=0x3ffffffff; out_valid exactly 78 cycles after accept.
- A=(2^34-1)*(2^43-1), B=2^43-1 -> Q=2^34-1, R=0 (round trip with the multiplier's max-operand result).
- A=100, B=7 -> Q=14, R=2. Also A=5, B=9 -> Q=0, R=5.
- A=0x123, B=0 -> Q=all ones, R=0x123, DZ=1 when INTDIV_DIV0_EN is defined.
- Hold out_ready=0 for 5 cycles after out_valid -> Q/R stable and in_ready=0. Pulse out_ready -> in_ready=1 next cycle. A new op is then accepted and correct.
- Assert rst at step 30 of RUN, then issue A=100, B=7 -> no stale out_valid; the new result Q=14, R=2 arrives at LAT.
